// File: rtl/axis_video_res_sequencer_pkg.sv
// Shared types for the AXIS video resolution sequencer: FSM states, resolution pair, SOF position.
// Pure declarations; no timing or flow-control behaviour lives here.
package axis_video_pkg;

   localparam int RES_W   = 12;
   localparam int SOF_BIT = 0;

   typedef enum logic [1:0] {RESET, SYNC, RUN, DRAIN} state_e;

   typedef struct packed {
      logic [RES_W-1:0] hres;
      logic [RES_W-1:0] vres;
   } res_t;

   // A zero dimension would wedge the converter, so it is never latched.
   function automatic logic res_valid(input res_t r);
      return (r.hres != '0) && (r.vres != '0);
   endfunction

endpackage

// File: rtl/axis_video_res_sequencer_filter.sv
// Debounces the requested resolution: pending once the request has held still for STABLE_CYCLES and differs from current.
// One-cycle input register; no stream interface, so no backpressure.
module res_stability_filter
   import axis_video_pkg::*;
#(
   parameter int STABLE_CYCLES = 1024,
   parameter int DEFAULT_HRES  = 1920,
   parameter int DEFAULT_VRES  = 1080
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  res_t req_i,
   input  res_t cur_i,
   output res_t cand_o,
   output logic pending_o
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   res_t             cand_q;
   logic [CNT_W-1:0] stable_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cand_q   <= '{hres: RES_W'(DEFAULT_HRES), vres: RES_W'(DEFAULT_VRES)};
         stable_q <= '0;
      end else begin
         cand_q <= req_i;
         if (req_i != cand_q) begin
            stable_q <= '0;
         end else if (stable_q != CNT_W'(STABLE_CYCLES)) begin
            stable_q <= stable_q + CNT_W'(1);
         end
      end
   end

   assign cand_o    = cand_q;
   assign pending_o = (stable_q == CNT_W'(STABLE_CYCLES)) && (cand_q != cur_i);

endmodule

// File: rtl/axis_video_res_sequencer.sv
// Sequences converter resets on resolution changes: drain frame, pulse reset, latch res, relock on SOF.
// Zero-latency pass-through in RUN/DRAIN (s_tready = m_tready); beats dropped in RESET/SYNC, SOF held in SYNC.
module axis_video_res_sequencer
   import axis_video_pkg::*;
#(
   parameter int DATA_WIDTH    = 24,
   parameter int TUSER_WIDTH   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int RESET_CYCLES  = 16,
   parameter int DRAIN_TIMEOUT = 1048576,
   parameter int DEFAULT_HRES  = 1920,
   parameter int DEFAULT_VRES  = 1080
) (
   input  logic                   i_axis_clk,
   input  logic                   i_axis_resetn,
   input  logic [RES_W-1:0]       i_hres,
   input  logic [RES_W-1:0]       i_vres,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   input  logic [TUSER_WIDTH-1:0] s_tuser,
   input  logic [DATA_WIDTH-1:0]  s_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic [TUSER_WIDTH-1:0] m_tuser,
   output logic [DATA_WIDTH-1:0]  m_tdata,
   output logic                   o_conv_reset,
   output logic [RES_W-1:0]       o_hres,
   output logic [RES_W-1:0]       o_vres,
   output logic                   o_locked,
   output logic [7:0]             o_change_cnt
);

   localparam int RST_W = $clog2(RESET_CYCLES);
   localparam int TMR_W = $clog2(DRAIN_TIMEOUT);

   state_e           state_q;
   res_t             res_q;
   logic             conv_reset_q, locked_q, first_q, in_frame_q, in_frame_d;
   logic [7:0]       change_cnt_q;
   logic [RST_W-1:0] rst_cnt_q;
   logic [TMR_W-1:0] timer_q;
   logic [RES_W-1:0] line_cnt_q, line_cnt_d;

   res_t cand, req;
   logic pending, pass, sof_wait, beat_acc, sof_acc, last_acc, drain_done, go_reset;

   assign req = '{hres: i_hres, vres: i_vres};

   res_stability_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .DEFAULT_HRES  (DEFAULT_HRES),
      .DEFAULT_VRES  (DEFAULT_VRES)
   ) u_filter (
      .clk_i     (i_axis_clk),
      .rst_n_i   (i_axis_resetn),
      .req_i     (req),
      .cur_i     (res_q),
      .cand_o    (cand),
      .pending_o (pending)
   );

   assign pass     = (state_q == RUN) || (state_q == DRAIN);
   assign sof_wait = (state_q == SYNC) && s_tvalid && s_tuser[SOF_BIT];
   assign m_tvalid = pass && s_tvalid;
   assign s_tready = pass ? m_tready : !sof_wait;
   assign m_tlast  = s_tlast;
   assign m_tuser  = s_tuser;
   assign m_tdata  = s_tdata;

   assign beat_acc = m_tvalid && m_tready;
   assign sof_acc  = beat_acc && s_tuser[SOF_BIT];
   assign last_acc = beat_acc && s_tlast;

   always_comb begin
      line_cnt_d = line_cnt_q;
      in_frame_d = in_frame_q;
      if (sof_acc) begin
         line_cnt_d = '0;
         in_frame_d = 1'b1;
      end
      if (last_acc) begin
         line_cnt_d = line_cnt_d + RES_W'(1);
         if (line_cnt_d == res_q.vres) in_frame_d = 1'b0;
      end
   end

   assign drain_done = last_acc && (line_cnt_q == res_q.vres - RES_W'(1));

   // Pending beats a same-cycle SOF in SYNC; DRAIN ignores further changes until it finishes.
   assign go_reset = ((state_q == RUN) && pending && !in_frame_q) ||
                     ((state_q == SYNC) && pending) ||
                     ((state_q == DRAIN) && (drain_done || (timer_q == TMR_W'(DRAIN_TIMEOUT - 1))));

   always_ff @(posedge i_axis_clk or negedge i_axis_resetn) begin
      if (!i_axis_resetn) begin
         state_q      <= RESET;
         res_q        <= '{hres: RES_W'(DEFAULT_HRES), vres: RES_W'(DEFAULT_VRES)};
         conv_reset_q <= 1'b1;
         locked_q     <= 1'b0;
         first_q      <= 1'b1;
         change_cnt_q <= '0;
         rst_cnt_q    <= '0;
         timer_q      <= '0;
         line_cnt_q   <= '0;
         in_frame_q   <= 1'b0;
      end else begin
         line_cnt_q <= line_cnt_d;
         in_frame_q <= in_frame_d;
         if (go_reset) begin
            state_q      <= RESET;
            conv_reset_q <= 1'b1;
            locked_q     <= 1'b0;
            rst_cnt_q    <= '0;
            if (res_valid(cand)) res_q <= cand;
         end else begin
            case (state_q)
               RUN: begin
                  if (pending) begin
                     state_q  <= DRAIN;
                     locked_q <= 1'b0;
                     timer_q  <= '0;
                  end
               end
               DRAIN: timer_q <= timer_q + TMR_W'(1);
               RESET: begin
                  // A change arriving mid-reset (or leaving a zero) is taken at once and restarts the pulse.
                  if (!res_valid(cand)) begin
                     rst_cnt_q <= '0;
                  end else if (cand != res_q) begin
                     res_q     <= cand;
                     rst_cnt_q <= '0;
                  end else if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                     state_q      <= SYNC;
                     conv_reset_q <= 1'b0;
                  end else begin
                     rst_cnt_q <= rst_cnt_q + RST_W'(1);
                  end
               end
               SYNC: begin
                  if (s_tvalid && s_tuser[SOF_BIT]) begin
                     state_q  <= RUN;
                     locked_q <= 1'b1;
                     if (first_q) first_q <= 1'b0;
                     else         change_cnt_q <= change_cnt_q + 8'd1;
                  end
               end
               default: state_q <= RESET;
            endcase
         end
      end
   end

   assign o_conv_reset = conv_reset_q;
   assign o_hres       = res_q.hres;
   assign o_vres       = res_q.vres;
   assign o_locked     = locked_q;
   assign o_change_cnt = change_cnt_q;

endmodule
